// File: rtl/serial_word_deserializer_if.sv
// Serial link plus parallel word handshake for serial_word_deserializer.
//   Serial side  : Serial_Valid_In, Serial_Data_In, Frame_Start_In (transmitter -> receiver)
//   Parallel side: Parallel_Data_Out, Parallel_Valid_Out (receiver -> consumer),
//                  Parallel_Ready_In (consumer -> receiver)
// Handshake: a word transfers on any rising edge where Parallel_Valid_Out=1 and
// Parallel_Ready_In=1; Parallel_Data_Out is stable while valid is high and
// no transfer occurs. Serial_Valid_In qualifies Serial_Data_In/Frame_Start_In
// in the same cycle; there is no back-pressure on the serial side.
// slave modport = receiver (the deserializer); master modport = its environment.
interface serial_word_deserializer_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  Serial_Valid_In;
  logic                  Serial_Data_In;
  logic                  Frame_Start_In;
  logic                  Parallel_Ready_In;
  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Parallel_Valid_Out;

  modport slave (
    input  Serial_Valid_In,
    input  Serial_Data_In,
    input  Frame_Start_In,
    input  Parallel_Ready_In,
    output Parallel_Data_Out,
    output Parallel_Valid_Out
  );

  modport master (
    output Serial_Valid_In,
    output Serial_Data_In,
    output Frame_Start_In,
    output Parallel_Ready_In,
    input  Parallel_Data_Out,
    input  Parallel_Valid_Out
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel receiver with a one-word holding register.
// Ports:
//   Clk_In            rising-edge clock
//   Reset_N_In        asynchronous active-low reset
//   Enable_In         0 freezes all state (handshake and error clear included)
//   Clear_Error_In    synchronous clear of Overrun_Error_Out (set wins)
//   bus               serial input + parallel valid/ready output (slave modport)
//   Busy_Out          a word is partially received (state SHIFT)
//   Overrun_Error_Out sticky: a completed word was dropped
//   Dbg_State_Out     FSM state (0 = IDLE, 1 = SHIFT)
module serial_word_deserializer #(
  parameter int DATA_WIDTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic Clk_In,
  input  logic Reset_N_In,
  input  logic Enable_In,
  input  logic Clear_Error_In,
  serial_word_deserializer_if.slave bus,
  output logic Busy_Out,
  output logic Overrun_Error_Out,
  output logic Dbg_State_Out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] shifted;   // sr with the current bit appended
  logic [DATA_WIDTH-1:0] fresh;     // register holding only a new bit 0
  logic                  complete;
  logic                  can_load;
  logic                  overrun;
  logic                  xfer;

  always_comb begin
    shifted = sr;
    fresh   = '0;
    if (MSB_FIRST) begin
      shifted = {sr[DATA_WIDTH-2:0], bus.Serial_Data_In};
      fresh   = {{(DATA_WIDTH-1){1'b0}}, bus.Serial_Data_In};
    end else begin
      shifted = {bus.Serial_Data_In, sr[DATA_WIDTH-1:1]};
      fresh   = {bus.Serial_Data_In, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // A frame start on what would be the last bit is a restart, not a completion.
  assign complete = (state == SHIFT) && bus.Serial_Valid_In && !bus.Frame_Start_In &&
                    (count == CW'(DATA_WIDTH - 1));
  assign xfer     = bus.Parallel_Valid_Out && bus.Parallel_Ready_In;
  // A held word being consumed on this edge frees the slot for the new word.
  assign can_load = !bus.Parallel_Valid_Out || bus.Parallel_Ready_In;
  assign overrun  = complete && !can_load;

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state                  <= IDLE;
      count                  <= '0;
      sr                     <= '0;
      bus.Parallel_Data_Out  <= '0;
      bus.Parallel_Valid_Out <= 1'b0;
      Busy_Out               <= 1'b0;
      Overrun_Error_Out      <= 1'b0;
    end else if (Enable_In) begin
      if (xfer) begin
        bus.Parallel_Valid_Out <= 1'b0;
      end
      if (bus.Serial_Valid_In) begin
        if (bus.Frame_Start_In) begin
          sr       <= fresh;
          count    <= CW'(1);
          state    <= SHIFT;
          Busy_Out <= 1'b1;
        end else if (state == SHIFT) begin
          sr <= shifted;
          if (complete) begin
            count    <= '0;
            state    <= IDLE;
            Busy_Out <= 1'b0;
            if (can_load) begin
              bus.Parallel_Data_Out  <= shifted;
              bus.Parallel_Valid_Out <= 1'b1;
            end
          end else begin
            count <= count + CW'(1);
          end
        end
      end
      Overrun_Error_Out <= overrun | (Overrun_Error_Out & ~Clear_Error_In);
    end
  end

  assign Dbg_State_Out = state;

endmodule

// File: tb/tb_serial_word_deserializer.sv
module tb_serial_word_deserializer;
  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  serial_word_deserializer_if #(.DATA_WIDTH(W)) bus_m ();
  serial_word_deserializer_if #(.DATA_WIDTH(W)) bus_l ();

  logic busy_m, err_m, st_m, busy_l, err_l, st_l;

  serial_word_deserializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Clear_Error_In(clr),
    .bus(bus_m.slave), .Busy_Out(busy_m), .Overrun_Error_Out(err_m), .Dbg_State_Out(st_m));

  serial_word_deserializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Clear_Error_In(clr),
    .bus(bus_l.slave), .Busy_Out(busy_l), .Overrun_Error_Out(err_l), .Dbg_State_Out(st_l));

  int compared = 0;
  int mismatched = 0;

  // reference model: bit list of the word in flight, holding register, flags
  int             m_bits[$];
  bit             m_busy;
  bit             m_valid;
  bit             m_err;
  logic [W-1:0]   m_data_m;
  logic [W-1:0]   m_data_l;
  logic [W-1:0]   exp_q[$];   // words expected to be handed to the consumer (MSB-first view)
  int             accepted;

  function automatic logic [W-1:0] assemble(bit msb_first);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++)
      if (m_bits[i] != 0) w = w | (msb_first ? (W'(1) << (W - 1 - i)) : (W'(1) << i));
    return w;
  endfunction

  function automatic void model_reset();
    m_bits.delete();
    m_busy = 0; m_valid = 0; m_err = 0; m_data_m = '0; m_data_l = '0;
  endfunction

  function automatic void model_edge(bit sv, bit sd, bit fs, bit c, bit rdy);
    bit complete = 0;
    bit set_err = 0;
    bit nvalid = m_valid && !rdy;
    if (m_valid && rdy) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      accepted++;
    end
    if (sv) begin
      if (fs) begin
        m_bits.delete(); m_bits.push_back(int'(sd)); m_busy = 1;
      end else if (m_busy) begin
        m_bits.push_back(int'(sd));
        if (m_bits.size() == W) begin complete = 1; m_busy = 0; end
      end
    end
    if (complete) begin
      if (!m_valid || rdy) begin
        m_data_m = assemble(1'b1); m_data_l = assemble(1'b0); nvalid = 1;
        exp_q.push_back(m_data_m);
      end else set_err = 1;
      m_bits.delete();
    end
    m_valid = nvalid;
    m_err = set_err ? 1'b1 : (c ? 1'b0 : m_err);
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("data_msb", 8'(bus_m.Parallel_Data_Out), 8'(m_data_m));
    chk("data_lsb", 8'(bus_l.Parallel_Data_Out), 8'(m_data_l));
    chk("valid_msb", 8'(bus_m.Parallel_Valid_Out), 8'(m_valid));
    chk("valid_lsb", 8'(bus_l.Parallel_Valid_Out), 8'(m_valid));
    chk("busy_msb", 8'(busy_m), 8'(m_busy));
    chk("busy_lsb", 8'(busy_l), 8'(m_busy));
    chk("err_msb", 8'(err_m), 8'(m_err));
    chk("err_lsb", 8'(err_l), 8'(m_err));
  endtask

  // driver: apply inputs on the falling edge, model the rising edge, check 1 time unit later
  task automatic step(bit e, bit sv, bit sd, bit fs, bit c, bit rdy);
    @(negedge clk);
    en = e; clr = c;
    bus_m.Serial_Valid_In = sv; bus_l.Serial_Valid_In = sv;
    bus_m.Serial_Data_In = sd;  bus_l.Serial_Data_In = sd;
    bus_m.Frame_Start_In = fs;  bus_l.Frame_Start_In = fs;
    bus_m.Parallel_Ready_In = rdy; bus_l.Parallel_Ready_In = rdy;
    @(posedge clk);
    if (e) model_edge(sv, sd, fs, c, rdy);
    #1;
    check_all();
  endtask

  task automatic send(bit sd, bit fs, bit rdy);
    step(1, 1, sd, fs, 0, rdy);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    bus_m.Serial_Valid_In = 0; bus_l.Serial_Valid_In = 0;
    bus_m.Serial_Data_In = 0;  bus_l.Serial_Data_In = 0;
    bus_m.Frame_Start_In = 0;  bus_l.Frame_Start_In = 0;
    bus_m.Parallel_Ready_In = 0; bus_l.Parallel_Ready_In = 0;
    model_reset();
    accepted = 0;

    // reset held, then released with no stimulus
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk); rst_n = 1'b1;
    idle(2, 0);
    // valid bits without frame start are ignored
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);

    // basic word 1,0,1,1 with ready low: B (msb-first) / D (lsb-first)
    send(1, 1, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    chk("basic_word_msb", 8'(bus_m.Parallel_Data_Out), 8'h0B);
    chk("basic_word_lsb", 8'(bus_l.Parallel_Data_Out), 8'h0D);
    idle(2, 0);
    idle(1, 1);   // ready pulse consumes the word
    idle(1, 0);

    // same bits with 2-cycle gaps
    send(1, 1, 0); idle(2, 0); send(0, 0, 0); idle(2, 0);
    send(1, 0, 0); idle(2, 0); send(1, 0, 0);
    chk("gap_word_lsb", 8'(bus_l.Parallel_Data_Out), 8'h0D);
    idle(1, 1);

    // restart: 1,1 then frame start with 0,0,1,0 -> 2
    send(1, 1, 0); send(1, 0, 0);
    send(0, 1, 0); send(0, 0, 0); send(1, 0, 0); send(0, 0, 0);
    chk("restart_word_msb", 8'(bus_m.Parallel_Data_Out), 8'h02);
    chk("restart_no_err", 8'(err_m), 8'h00);
    idle(1, 1);
    // frame start on the would-be last bit restarts instead of completing
    send(1, 1, 0); send(1, 0, 0); send(1, 0, 0); send(0, 1, 0);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    idle(1, 1);

    // overrun: hold B, receive 5 -> dropped, error set
    send(1, 1, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    send(0, 1, 0); send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    chk("overrun_hold_msb", 8'(bus_m.Parallel_Data_Out), 8'h0B);
    chk("overrun_err", 8'(err_m), 8'h01);
    // ready on the completion edge: 5 replaces B, valid stays high
    send(0, 1, 0); send(1, 0, 0); send(0, 0, 0); send(1, 0, 1);
    chk("pass_through_msb", 8'(bus_m.Parallel_Data_Out), 8'h05);
    // clear and set in the same cycle: set wins
    send(1, 1, 0); send(1, 0, 0); send(1, 0, 0); step(1, 1, 1, 0, 1, 0);
    chk("set_beats_clear", 8'(err_m), 8'h01);
    step(1, 0, 0, 0, 1, 0);   // clear pulse
    chk("err_cleared", 8'(err_m), 8'h00);
    idle(1, 1);

    // enable dropped mid-word while inputs toggle
    send(0, 1, 0); send(1, 0, 0);
    step(0, 1, 1, 1, 1, 1); step(0, 1, 0, 0, 0, 1); step(0, 0, 1, 1, 1, 0);
    send(1, 0, 0); send(0, 0, 0);
    chk("enable_resume_msb", 8'(bus_m.Parallel_Data_Out), 8'h06);
    idle(1, 1);

    // asynchronous reset after 2 bits, away from any clock edge
    send(1, 1, 0); send(1, 0, 0);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    model_reset();
    check_all();
    @(negedge clk); rst_n = 1'b1;
    idle(1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit sv = ($urandom_range(0, 3) != 0);
      bit fs = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 9) != 0), sv, 1'($urandom_range(0, 1)), fs,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
- Receive-side partner to the 4-bit universal shift register when it is used as a serial transmitter.
- Samples a framed serial bit stream, assembles DATA_WIDTH-bit words, and presents each word on a parallel output.
- The output uses a valid/ready handshake and a one-word holding register.
- Sits at the receiving end of a serial link between shift-register blocks; overruns are flagged with a sticky error.

Parameters:
DATA_WIDTH, 4, word length in bits (2 or more).
MSB_FIRST, 1, 1 = first received bit lands in the MSB (matches left-shift transmit); 0 = first bit lands in the LSB.

Ports:
Clk_In  input  1  clock; all state updates on the rising edge (the transmitter launches on the falling edge, giving half-cycle margin).
Reset_N_In  input  1  asynchronous, active-low reset.
Enable_In  input  1  1 = normal operation; 0 = all state frozen, inputs ignored.
Serial_Valid_In  input  1  qualifies Serial_Data_In this cycle.
Serial_Data_In  input  1  serial data bit.
Frame_Start_In  input  1  marks the current valid bit as the first bit of a word; ignored unless Serial_Valid_In=1.
Clear_Error_In  input  1  synchronous clear of Overrun_Error_Out.
Parallel_Ready_In  input  1  consumer accepts Parallel_Data_Out when Parallel_Valid_Out=1.
Parallel_Data_Out  output  DATA_WIDTH  assembled word (holding register).
Parallel_Valid_Out  output  1  holding register contains an unconsumed word.
Busy_Out  output  1  a word is partially received (state SHIFT).
Overrun_Error_Out  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (Reset_N_In=0, immediate): state=IDLE, bit counter=0, shift register=0, Parallel_Data_Out=0, Parallel_Valid_Out=0, Busy_Out=0, Overrun_Error_Out=0. Reset mid-word discards the partial word and any held word.
- Enable_In=0: no state, counter, register or flag changes, including the handshake and Clear_Error_In. Outputs hold their last values.
- States: IDLE, SHIFT.
- IDLE:
  - Serial_Valid_In=1 and Frame_Start_In=1: capture bit 0, counter=1, go to SHIFT.
  - Valid bits without Frame_Start_In are ignored.
- SHIFT:
  - Each Serial_Valid_In=1 cycle captures one bit and increments the counter.
  - Cycles with Serial_Valid_In=0 insert gaps and change nothing.
- Bit placement:
  - MSB_FIRST=1: shift register <= {sr[DATA_WIDTH-2:0], bit}.
  - MSB_FIRST=0: shift register <= {bit, sr[DATA_WIDTH-1:1]}.
- Frame_Start_In with a valid bit while in SHIFT: discard the partial word, restart with this bit as bit 0, counter=1, stay in SHIFT. No error is raised.
- Word completion happens on the edge that captures bit DATA_WIDTH-1:
  - The assembled word (including that bit) is offered to the holding register.
  - Counter=0, state=IDLE.
  - If that bit also carries Frame_Start_In, it is treated as the restart case, not a completion.
- Holding register load, evaluated at the completion edge:
  - Empty (Parallel_Valid_Out=0), or Parallel_Valid_Out=1 and Parallel_Ready_In=1 on the same edge: load the word; Parallel_Valid_Out=1 after the edge.
  - Otherwise: the new word is dropped, the held word is preserved, and Overrun_Error_Out=1.
- Latency: word visible with Parallel_Valid_Out=1 in the cycle after its last bit is sampled.
- Handshake:
  - Transfer occurs on any edge with Parallel_Valid_Out=1 and Parallel_Ready_In=1.
  - With no simultaneous completion, Parallel_Valid_Out=0 after the edge and Parallel_Data_Out holds its value.
  - Parallel_Data_Out must not change while Parallel_Valid_Out=1 and no transfer occurs.
- Overrun_Error_Out:
  - Set has priority over Clear_Error_In in the same cycle.
  - Otherwise Clear_Error_In=1 clears it on the next edge.
- Busy_Out = (state==SHIFT).

Test Plan:
- Reset/idle: hold Reset_N_In=0, then release with no stimulus -> all outputs 0. Valid bits without Frame_Start_In -> no change.
- Basic word, MSB_FIRST=1: send bits 1,0,1,1 (Frame_Start_In on the first), Parallel_Ready_In=0 -> Parallel_Data_Out=4'hB, Parallel_Valid_Out=1 the cycle after the 4th bit; Busy_Out=1 during bits 2-4. Pulse ready -> Parallel_Valid_Out=0 after the edge.
- Gaps and LSB-first: MSB_FIRST=0, same bits with 2-cycle gaps between them -> Parallel_Data_Out=4'hD.
- Restart: send 1,1, then Frame_Start_In with bits 0,0,1,0 -> word 4'h2; no error raised.
- Overrun: hold 4'hB unaccepted, receive 4'h5 -> data stays 4'hB, Overrun_Error_Out=1. Repeat with ready asserted on the completion edge -> data becomes 4'h5, valid stays 1, no error. Pulse Clear_Error_In -> error cleared.
- Enable and reset mid-word: drop Enable_In for 3 cycles mid-word while toggling inputs -> resumes, word unaffected. Assert Reset_N_In after 2 bits -> asynchronous clear, Busy_Out=0 immediately.
